pwm_carrier_ctrl: RTL and testbench

PWM_CARRIER_CTRL -- requirements
Module: pwm_carrier_ctrl

---
 rtl/ddfs_pwm_pkg.sv | 36 +++
 rtl/pwm_tri_counter.sv | 90 +++++++++
 rtl/pwm_carrier_ctrl.sv | 140 ++++++++++++++
 tb/tb_pwm_carrier_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ddfs_pwm_pkg.sv
// Shared definitions for the PWM triangle-carrier controller.
//   - carrier_state_t : controller FSM state encoding
//   - CARRIER_W/CFG_W : carrier (signed) and config (unsigned) widths
//   - default and limit constants for the carrier configuration
//   - neg_peak()      : signed -peak at carrier width
//   - cfg_is_bad()    : config legality check
package ddfs_pwm_pkg;

  localparam int CARRIER_W = 17;
  localparam int CFG_W     = 16;

  localparam logic [CFG_W-1:0] DEF_PEAK = 16'd32767;
  localparam logic [CFG_W-1:0] DEF_STEP = 16'd64;
  localparam logic [CFG_W-1:0] MAX_PEAK = 16'd32767;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } carrier_state_t;

  // -peak as a carrier-width signed value; peak is at most 16 bits unsigned,
  // so one extra sign bit always suffices.
  function automatic logic signed [CARRIER_W-1:0] neg_peak(input logic [CFG_W-1:0] p);
    logic signed [CARRIER_W-1:0] ext;
    ext = $signed({1'b0, p});
    return -ext;
  endfunction

  // A config is unusable if it would stall the carrier (zero step/peak),
  // overflow the signed carrier range, or overshoot both rails in one step.
  function automatic logic cfg_is_bad(input logic [CFG_W-1:0] p, input logic [CFG_W-1:0] s);
    return (p == '0) || (p > MAX_PEAK) || (s == '0) || (s > p);
  endfunction

endpackage

// File: rtl/pwm_tri_counter.sv
// Up/down clamping triangle counter.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   start         : load load_val, direction up, pulse valley
//   adv           : advance one step toward the current rail
//   peak, step    : active amplitude and increment (unsigned)
//   load_val      : value taken on start or when a down step hits the valley
//   tri_out       : signed carrier
//   valley, crest : registered one-cycle rail pulses
//   at_valley     : combinational look-ahead: the next down step reaches -peak
module pwm_tri_counter
  import ddfs_pwm_pkg::*;
(
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        adv,
  input  logic [CFG_W-1:0]            peak,
  input  logic [CFG_W-1:0]            step,
  input  logic signed [CARRIER_W-1:0] load_val,
  output logic signed [CARRIER_W-1:0] tri_out,
  output logic                        valley,
  output logic                        crest,
  output logic                        at_valley
);

  logic signed [CARRIER_W-1:0] tri_reg;
  logic                        up_reg;
  logic                        valley_reg;
  logic                        crest_reg;

  // One guard bit beyond the carrier so the overshoot is visible before
  // clamping instead of wrapping.
  logic signed [CARRIER_W:0] tri_ext;
  logic signed [CARRIER_W:0] peak_ext;
  logic signed [CARRIER_W:0] step_ext;
  logic signed [CARRIER_W:0] sum;
  logic signed [CARRIER_W:0] diff;
  logic                      at_crest;

  always_comb begin
    tri_ext   = {tri_reg[CARRIER_W-1], tri_reg};
    peak_ext  = $signed({2'b00, peak});
    step_ext  = $signed({2'b00, step});
    sum       = tri_ext + step_ext;
    diff      = tri_ext - step_ext;
    at_crest  = up_reg && (sum >= peak_ext);
    at_valley = !up_reg && (diff <= -peak_ext);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tri_reg    <= '0;
      up_reg     <= 1'b1;
      valley_reg <= 1'b0;
      crest_reg  <= 1'b0;
    end else begin
      valley_reg <= 1'b0;
      crest_reg  <= 1'b0;
      if (start) begin
        tri_reg    <= load_val;
        up_reg     <= 1'b1;
        valley_reg <= 1'b1;
      end else if (adv) begin
        if (up_reg) begin
          if (at_crest) begin
            tri_reg   <= $signed({1'b0, peak});
            up_reg    <= 1'b0;
            crest_reg <= 1'b1;
          end else begin
            tri_reg <= sum[CARRIER_W-1:0];
          end
        end else begin
          if (at_valley) begin
            tri_reg    <= load_val;
            up_reg     <= 1'b1;
            valley_reg <= 1'b1;
          end else begin
            tri_reg <= diff[CARRIER_W-1:0];
          end
        end
      end
    end
  end

  assign tri_out = tri_reg;
  assign valley  = valley_reg;
  assign crest   = crest_reg;

endmodule

// File: rtl/pwm_carrier_ctrl.sv
// PWM triangle-carrier controller: run/stop FSM, config handshake and
// shadow (pending) config register around pwm_tri_counter.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   en                   : run request (level)
//   cfg_valid/cfg_ready  : config handshake; cfg_peak/cfg_step payload
//   tri_out              : signed triangle carrier
//   valley, crest        : one-cycle rail pulses
//   running              : high in RUN and STOP
//   cfg_err              : one-cycle pulse after a rejected config
module pwm_carrier_ctrl
  import ddfs_pwm_pkg::*;
#(
  parameter logic [CFG_W-1:0] DEFAULT_PEAK = DEF_PEAK,
  parameter logic [CFG_W-1:0] DEFAULT_STEP = DEF_STEP
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        en,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [CFG_W-1:0]            cfg_peak,
  input  logic [CFG_W-1:0]            cfg_step,
  output logic signed [CARRIER_W-1:0] tri_out,
  output logic                        valley,
  output logic                        crest,
  output logic                        running,
  output logic                        cfg_err
);

  carrier_state_t   state;
  carrier_state_t   state_next;
  logic [CFG_W-1:0] active_peak;
  logic [CFG_W-1:0] active_step;
  logic             pend;
  logic [CFG_W-1:0] pend_peak;
  logic [CFG_W-1:0] pend_step;
  logic             running_reg;
  logic             cfg_err_reg;

  logic                        accept;
  logic                        bad;
  logic                        take;
  logic                        start;
  logic                        adv;
  logic                        valley_evt;
  logic                        at_valley;
  logic signed [CARRIER_W-1:0] load_val;

  assign cfg_ready = (state == ST_IDLE) || !pend;
  assign accept    = cfg_valid && cfg_ready;
  assign bad       = cfg_is_bad(cfg_peak, cfg_step);
  assign take      = accept && !bad;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    adv        = 1'b0;
    valley_evt = 1'b0;
    load_val   = pend ? neg_peak(pend_peak) : neg_peak(active_peak);
    unique case (state)
      ST_IDLE: begin
        if (en) begin
          start      = 1'b1;
          state_next = ST_RUN;
          // A config accepted on the same edge is already the one in force.
          load_val   = neg_peak(take ? cfg_peak : active_peak);
        end
      end
      ST_RUN: begin
        adv        = 1'b1;
        valley_evt = at_valley;
        if (!en) state_next = ST_STOP;
      end
      ST_STOP: begin
        adv        = 1'b1;
        valley_evt = at_valley;
        if (en) begin
          state_next = ST_RUN;
        end else if (at_valley) begin
          state_next = ST_IDLE;
          load_val   = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      active_peak <= DEFAULT_PEAK;
      active_step <= DEFAULT_STEP;
      pend        <= 1'b0;
      pend_peak   <= '0;
      pend_step   <= '0;
      running_reg <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      state       <= state_next;
      running_reg <= (state_next != ST_IDLE);
      cfg_err_reg <= accept && bad;
      // Only a config pending before this edge is applied; one accepted on
      // the valley edge itself waits for the next valley.
      if (valley_evt && pend) begin
        active_peak <= pend_peak;
        active_step <= pend_step;
        pend        <= 1'b0;
      end
      if (take) begin
        if (state == ST_IDLE) begin
          active_peak <= cfg_peak;
          active_step <= cfg_step;
        end else begin
          pend      <= 1'b1;
          pend_peak <= cfg_peak;
          pend_step <= cfg_step;
        end
      end
    end
  end

  pwm_tri_counter u_cnt (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .adv       (adv),
    .peak      (active_peak),
    .step      (active_step),
    .load_val  (load_val),
    .tri_out   (tri_out),
    .valley    (valley),
    .crest     (crest),
    .at_valley (at_valley)
  );

  assign running = running_reg;
  assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_pwm_carrier_ctrl.sv
// Directed testbench for pwm_carrier_ctrl.
module tb_pwm_carrier_ctrl;

  logic               clk;
  logic               resetn;
  logic               en;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [15:0]        cfg_peak;
  logic [15:0]        cfg_step;
  logic signed [16:0] tri_out;
  logic               valley;
  logic               crest;
  logic               running;
  logic               cfg_err;

  int vecs;
  int errs;

  pwm_carrier_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_peak  (cfg_peak),
    .cfg_step  (cfg_step),
    .tri_out   (tri_out),
    .valley    (valley),
    .crest     (crest),
    .running   (running),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One tick per expected carrier value; crest/valley expected only at the
  // given indices (-1 = never).
  task automatic expect_seq(input string tag, input int vals[$], input int ci, input int vi);
    for (int i = 0; i < vals.size(); i++) begin
      tick();
      check($sformatf("%s.tri[%0d]", tag, i), tri_out, vals[i]);
      check($sformatf("%s.crest[%0d]", tag, i), crest, (i == ci) ? 1 : 0);
      check($sformatf("%s.valley[%0d]", tag, i), valley, (i == vi) ? 1 : 0);
      $display("%s step %0d: tri_out=%0d crest=%0b valley=%0b running=%0b",
               tag, i, tri_out, crest, valley, running);
    end
  endtask

  task automatic offer(input int p, input int s);
    cfg_valid = 1'b1;
    cfg_peak  = 16'(p);
    cfg_step  = 16'(s);
  endtask

  initial begin
    vecs      = 0;
    errs      = 0;
    resetn    = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_peak  = '0;
    cfg_step  = '0;

    // Reset state
    tick();
    check("rst.tri", tri_out, 0);
    check("rst.valley", valley, 0);
    check("rst.crest", crest, 0);
    check("rst.running", running, 0);
    check("rst.cfg_ready", cfg_ready, 1);
    check("rst.cfg_err", cfg_err, 0);
    $display("reset: tri_out=%0d running=%0b cfg_ready=%0b", tri_out, running, cfg_ready);

    resetn = 1'b1;
    tick();
    check("idle.tri", tri_out, 0);
    check("idle.running", running, 0);

    // Config 100/25 in IDLE, then run a full period
    offer(100, 25);
    tick();
    cfg_valid = 1'b0;
    check("cfg25.err", cfg_err, 0);
    check("cfg25.tri", tri_out, 0);
    $display("cfg 100/25 accepted in IDLE");

    en = 1'b1;
    tick();
    check("run25.entry_tri", tri_out, -100);
    check("run25.entry_valley", valley, 1);
    check("run25.entry_running", running, 1);
    expect_seq("p25", '{-75, -50, -25, 0, 25, 50, 75, 100,
                        75, 50, 25, 0, -25, -50, -75, -100}, 7, 15);

    // Drop en, re-raise before valley: carrier continuous
    en = 1'b0;
    expect_seq("stop_a", '{-75, -50, -25, 0}, -1, -1);
    check("stop_a.running", running, 1);
    en = 1'b1;
    expect_seq("resume", '{25, 50, 75, 100, 75}, 3, -1);
    // Drop en and ride to the valley: goes IDLE with tri_out=0
    en = 1'b0;
    expect_seq("stop_b", '{50, 25, 0, -25, -50, -75}, -1, -1);
    check("stop_b.running", running, 1);
    tick();
    check("stop_end.tri", tri_out, 0);
    check("stop_end.valley", valley, 1);
    check("stop_end.running", running, 0);
    $display("stop to idle: tri_out=%0d valley=%0b running=%0b", tri_out, valley, running);
    tick();
    check("idle2.tri", tri_out, 0);
    check("idle2.valley", valley, 0);
    check("idle2.running", running, 0);

    // Config 100/30: clamped crest and valley
    offer(100, 30);
    tick();
    cfg_valid = 1'b0;
    check("cfg30.err", cfg_err, 0);
    en = 1'b1;
    tick();
    check("run30.entry_tri", tri_out, -100);
    check("run30.entry_valley", valley, 1);
    expect_seq("p30", '{-70, -40, -10, 20, 50, 80, 100,
                        70, 40, 10, -20, -50, -80, -100}, 6, 13);

    // Reconfigure 50/25 mid-ramp: pending until next valley
    tick();
    check("pend.pre_tri", tri_out, -70);
    check("pend.pre_ready", cfg_ready, 1);
    offer(50, 25);
    tick();
    cfg_valid = 1'b0;
    check("pend.ready_low", cfg_ready, 0);
    check("pend.err", cfg_err, 0);
    check("pend.tri", tri_out, -40);
    $display("pending cfg 50/25: cfg_ready=%0b tri_out=%0d", cfg_ready, tri_out);
    expect_seq("old", '{-10, 20, 50, 80, 100, 70, 40, 10, -20, -50, -80, -50}, 4, 11);
    check("pend.ready_back", cfg_ready, 1);
    expect_seq("new", '{-25, 0, 25, 50}, 3, -1);

    // Rejected configs: step=0, then peak=40000
    offer(50, 0);
    tick();
    cfg_valid = 1'b0;
    check("bad_step.err", cfg_err, 1);
    check("bad_step.tri", tri_out, 25);
    check("bad_step.ready", cfg_ready, 1);
    $display("bad cfg step=0: cfg_err=%0b tri_out=%0d", cfg_err, tri_out);
    tick();
    check("bad_step.err_clr", cfg_err, 0);
    check("bad_step.tri2", tri_out, 0);
    offer(40000, 10);
    tick();
    cfg_valid = 1'b0;
    check("bad_peak.err", cfg_err, 1);
    check("bad_peak.tri", tri_out, -25);
    $display("bad cfg peak=40000: cfg_err=%0b tri_out=%0d", cfg_err, tri_out);
    tick();
    check("bad_peak.err_clr", cfg_err, 0);
    check("bad_peak.tri2", tri_out, -50);
    check("bad_peak.valley", valley, 1);
    expect_seq("after_bad", '{-25, 0}, -1, -1);

    // Asynchronous reset mid-RUN, then defaults
    #2;
    resetn = 1'b0;
    #1;
    check("arst.tri", tri_out, 0);
    check("arst.running", running, 0);
    check("arst.cfg_ready", cfg_ready, 1);
    $display("async reset mid-run: tri_out=%0d running=%0b", tri_out, running);
    tick();
    resetn = 1'b1;
    tick();
    check("def.entry_tri", tri_out, -32767);
    check("def.entry_valley", valley, 1);
    check("def.running", running, 1);
    expect_seq("def", '{-32703, -32639}, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
